// File: rtl/digit_serial_adder_pkg.sv
// Shared definitions for the digit-serial adder: FSM state encoding and
// the digit-counter width helper.
package digit_serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Counter width for a given number of digits; never narrower than one bit
  // so the single-digit configuration still has a legal counter.
  function automatic int cnt_width(input int digits);
    return (digits <= 2) ? 1 : $clog2(digits);
  endfunction

endpackage

// File: rtl/digit_serial_adder_if.sv
// Operand/result handshake bundle of the digit-serial adder.
// master: operand producer + result consumer; slave: the adder itself.
interface digit_serial_adder_if #(
  parameter int N = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [N:0]   r;
  logic         ovf;
  logic         busy;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, r, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, r, ovf, busy
  );
endinterface

// File: rtl/digit_serial_adder_digit.sv
// Combinational W-bit ripple adder cell. Besides the carry out it exposes
// the carry into the top bit so the caller can derive signed overflow.
module digit_adder #(
  parameter int W = 2
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co,
  output logic         c_msb_in
);

  // Ripple the carry through the W bits, tapping it just before the MSB
  always_comb begin : p_ripple
    logic c;
    c        = ci;
    s        = '0;
    c_msb_in = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (i == W - 1) c_msb_in = c;
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    co = c;
  end

endmodule

// File: rtl/digit_serial_adder.sv
// Multi-cycle N-bit adder/subtractor. Operands are latched on the accept
// edge and consumed DIGIT bits per clock, LSB first, through one narrow
// ripple cell; the carry is kept in a register between digits.
module digit_serial_adder
  import digit_serial_adder_pkg::*;
#(
  parameter int N     = 8,
  parameter int DIGIT = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  digit_serial_adder_if.slave  bus
);

  localparam int D  = N / DIGIT;
  localparam int CW = cnt_width(D);

  generate
    if (N % DIGIT != 0) begin : g_bad_digit
      $error("digit_serial_adder: N must be a multiple of DIGIT");
    end
  endgenerate

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   cnt;
  logic [N-1:0]    op_a;
  logic [N-1:0]    op_b;
  logic            carry;
  logic [N:0]      r_q;
  logic            ovf_q;
  logic            in_ready_int;
  logic            accept;
  logic            last;
  logic [DIGIT-1:0] dsum;
  logic            dco;
  logic            dmsb;

  // Drop the consumed digit; zeros enter at the top
  function automatic logic [N-1:0] shift_digit(input logic [N-1:0] v);
    return v >> DIGIT;
  endfunction

  assign last         = (cnt == CW'(D - 1));
  // Ready in IDLE, or in DONE when the result leaves on this same edge
  assign in_ready_int = (state == ST_IDLE) || ((state == ST_DONE) && bus.out_ready);
  assign accept       = bus.in_valid && in_ready_int;

  digit_adder #(.W(DIGIT)) u_cell (
    .x        (op_a[DIGIT-1:0]),
    .y        (op_b[DIGIT-1:0]),
    .ci       (carry),
    .s        (dsum),
    .co       (dco),
    .c_msb_in (dmsb)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bus.in_valid) state_nxt = ST_BUSY;
      ST_BUSY: if (last)         state_nxt = ST_DONE;
      ST_DONE: begin
        if (bus.out_ready) state_nxt = bus.in_valid ? ST_BUSY : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Digit counter, inter-digit carry and result/overflow registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      carry <= 1'b0;
      r_q   <= '0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      // Subtraction is a + ~b + 1: the +1 enters as the initial carry
      carry <= bus.sub ? 1'b1 : bus.cin;
      cnt   <= '0;
    end else if (state == ST_BUSY) begin
      carry <= dco;
      cnt   <= cnt + 1'b1;
      for (int k = 0; k < D; k++) begin
        if (cnt == CW'(k)) r_q[k*DIGIT +: DIGIT] <= dsum;
      end
      if (last) begin
        r_q[N] <= dco;
        ovf_q  <= dmsb ^ dco;
      end
    end
  end

  // Operand shift registers; contents are don't-care outside BUSY
  always_ff @(posedge clk) begin
    if (accept) begin
      op_a <= bus.a;
      op_b <= bus.sub ? ~bus.b : bus.b;
    end else if (state == ST_BUSY) begin
      op_a <= shift_digit(op_a);
      op_b <= shift_digit(op_b);
    end
  end

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = (state == ST_DONE);
  assign bus.busy      = (state == ST_BUSY);
  assign bus.r         = r_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Self-checking bench for digit_serial_adder: one instance with DIGIT=2
// (four digits) and one with DIGIT=8 (single BUSY cycle). Expected results
// are queued as {ovf, r} when operands are accepted and popped on output.
module tb_digit_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  digit_serial_adder_if #(.N(8)) bus2 ();
  digit_serial_adder_if #(.N(8)) bus8 ();

  digit_serial_adder #(.N(8), .DIGIT(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
  digit_serial_adder #(.N(8), .DIGIT(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [9:0] sb_q[$];

  // Reference: plain integer arithmetic, signed range check for overflow
  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b,
                                       input logic cin, input logic sub);
    int         sa, sb, sr;
    logic [8:0] rr;
    logic       ov;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sub) begin
      rr[7:0] = a - b;
      rr[8]   = (a >= b);
      sr      = sa - sb;
    end else begin
      rr = {1'b0, a} + {1'b0, b} + {8'b0, cin};
      sr = sa + sb + int'(cin);
    end
    ov = (sr > 127) || (sr < -128);
    return {ov, rr};
  endfunction

  task automatic op2(input logic [7:0] a, input logic [7:0] b, input logic cin,
                     input logic sub, output logic [8:0] r, output logic ovf,
                     output int lat);
    int g;
    @(negedge clk);
    bus2.a = a; bus2.b = b; bus2.cin = cin; bus2.sub = sub;
    bus2.in_valid = 1'b1; bus2.out_ready = 1'b0;
    g = 0;
    #1;
    while (!bus2.in_ready && g < 100) begin @(negedge clk); #1; g++; end
    @(negedge clk);
    // Scramble the inputs during BUSY; they must be ignored
    bus2.in_valid = 1'b0;
    bus2.a = ~a; bus2.b = a ^ b; bus2.cin = ~cin; bus2.sub = ~sub;
    lat = 0;
    while (!bus2.out_valid && lat < 50) begin @(negedge clk); lat++; end
    r = bus2.r; ovf = bus2.ovf;
    bus2.out_ready = 1'b1;
    @(negedge clk);
    bus2.out_ready = 1'b0;
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                     input logic sub, output logic [8:0] r, output logic ovf,
                     output int lat);
    int g;
    @(negedge clk);
    bus8.a = a; bus8.b = b; bus8.cin = cin; bus8.sub = sub;
    bus8.in_valid = 1'b1; bus8.out_ready = 1'b0;
    g = 0;
    #1;
    while (!bus8.in_ready && g < 100) begin @(negedge clk); #1; g++; end
    @(negedge clk);
    bus8.in_valid = 1'b0;
    bus8.a = ~a; bus8.b = a ^ b; bus8.cin = ~cin; bus8.sub = ~sub;
    lat = 0;
    while (!bus8.out_valid && lat < 50) begin @(negedge clk); lat++; end
    r = bus8.r; ovf = bus8.ovf;
    bus8.out_ready = 1'b1;
    @(negedge clk);
    bus8.out_ready = 1'b0;
  endtask

  // Run one DIGIT=2 operation and compare against the queued expectation
  task automatic run_dir(input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic sub, input logic [9:0] exp_v,
                         input int exp_lat);
    logic [8:0] r; logic ovf; int lat; logic [9:0] e;
    sb_q.push_back(exp_v);
    op2(a, b, cin, sub, r, ovf, lat);
    e = sb_q.pop_front();
    n_checks++;
    if ({ovf, r} !== e) begin
      n_fail++;
      $display("FAIL %s: got ovf=%b r=%h, expected ovf=%b r=%h", name, ovf, r, e[9], e[8:0]);
    end
    if (exp_lat > 0) begin
      n_checks++;
      if (lat !== exp_lat) begin
        n_fail++;
        $display("FAIL %s_latency: got %0d edges, expected %0d", name, lat, exp_lat);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus2.in_ready, bus2.out_valid, bus2.busy, bus2.ovf, bus2.r} !== {4'b1000, 9'h000}) begin
      n_fail++;
      $display("FAIL reset_state: got rdy=%b vld=%b busy=%b ovf=%b r=%h, expected 1 0 0 0 000",
               bus2.in_ready, bus2.out_valid, bus2.busy, bus2.ovf, bus2.r);
    end
    rst_n = 1'b1;
    run_dir("pre_reset_op", 8'h12, 8'h01, 1'b0, 1'b0, {1'b0, 9'h013}, 0);
    // Start an operation and reset it part way through BUSY
    @(negedge clk);
    bus2.a = 8'h55; bus2.b = 8'h33; bus2.cin = 1'b0; bus2.sub = 1'b0; bus2.in_valid = 1'b1;
    @(negedge clk);
    bus2.in_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus2.in_ready, bus2.out_valid, bus2.busy, bus2.ovf, bus2.r} !== {4'b1000, 9'h000}) begin
      n_fail++;
      $display("FAIL reset_mid_busy: got rdy=%b vld=%b busy=%b ovf=%b r=%h, expected 1 0 0 0 000",
               bus2.in_ready, bus2.out_valid, bus2.busy, bus2.ovf, bus2.r);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_dir("post_reset_op", 8'h01, 8'h01, 1'b0, 1'b0, {1'b0, 9'h002}, 4);
  endtask

  task automatic test_add();
    run_dir("add_12_01", 8'h12, 8'h01, 1'b0, 1'b0, {1'b0, 9'h013}, 4);
    run_dir("add_12_01_cin", 8'h12, 8'h01, 1'b1, 1'b0, {1'b0, 9'h014}, 4);
  endtask

  task automatic test_carry_ovf();
    run_dir("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, {1'b0, 9'h100}, 0);
    run_dir("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, {1'b1, 9'h080}, 0);
  endtask

  task automatic test_sub();
    run_dir("sub_10_20", 8'h10, 8'h20, 1'b0, 1'b1, {1'b0, 9'h0F0}, 0);
    run_dir("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1, {1'b1, 9'h17F}, 0);
    run_dir("sub_05_05", 8'h05, 8'h05, 1'b1, 1'b1, {1'b0, 9'h100}, 0);
  endtask

  task automatic test_back_to_back();
    int g; logic [9:0] e;
    @(negedge clk);
    bus2.a = 8'h21; bus2.b = 8'h43; bus2.cin = 1'b0; bus2.sub = 1'b0;
    bus2.in_valid = 1'b1; bus2.out_ready = 1'b0;
    sb_q.push_back({1'b0, 9'h064});
    @(negedge clk);
    bus2.in_valid = 1'b0;
    g = 0;
    while (!bus2.out_valid && g < 50) begin @(negedge clk); g++; end
    // Present the next operation while the consumer stalls
    bus2.a = 8'h30; bus2.b = 8'h05; bus2.cin = 1'b0; bus2.sub = 1'b1; bus2.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if ({bus2.out_valid, bus2.in_ready, bus2.ovf, bus2.r} !== {2'b10, sb_q[0]}) begin
        n_fail++;
        $display("FAIL stall_cycle%0d: got vld=%b rdy=%b ovf=%b r=%h, expected vld=1 rdy=0 ovf=%b r=%h",
                 i, bus2.out_valid, bus2.in_ready, bus2.ovf, bus2.r, sb_q[0][9], sb_q[0][8:0]);
      end
      @(negedge clk);
    end
    bus2.out_ready = 1'b1;
    #1;
    e = sb_q.pop_front();
    sb_q.push_back(model(8'h30, 8'h05, 1'b0, 1'b1));
    n_checks++;
    if ({bus2.in_ready, bus2.ovf, bus2.r} !== {1'b1, e}) begin
      n_fail++;
      $display("FAIL release: got rdy=%b ovf=%b r=%h, expected rdy=1 ovf=%b r=%h",
               bus2.in_ready, bus2.ovf, bus2.r, e[9], e[8:0]);
    end
    @(negedge clk);
    bus2.out_ready = 1'b0; bus2.in_valid = 1'b0;
    n_checks++;
    if ({bus2.busy, bus2.out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL b2b_accept: got busy=%b vld=%b, expected busy=1 vld=0", bus2.busy, bus2.out_valid);
    end
    g = 0;
    while (!bus2.out_valid && g < 50) begin @(negedge clk); g++; end
    e = sb_q.pop_front();
    n_checks++;
    if ({bus2.out_valid, bus2.ovf, bus2.r} !== {1'b1, e}) begin
      n_fail++;
      $display("FAIL b2b_result: got vld=%b ovf=%b r=%h, expected vld=1 ovf=%b r=%h",
               bus2.out_valid, bus2.ovf, bus2.r, e[9], e[8:0]);
    end
    bus2.out_ready = 1'b1;
    @(negedge clk);
    bus2.out_ready = 1'b0;
  endtask

  task automatic test_random();
    localparam int NOPS = 1000;
    fork
      begin : producer
        logic [7:0] a, b; logic cin, sub; int g;
        for (int i = 0; i < NOPS; i++) begin
          repeat ($urandom_range(0, 2)) begin @(negedge clk); bus2.in_valid = 1'b0; end
          @(negedge clk);
          a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
          bus2.a = a; bus2.b = b; bus2.cin = cin; bus2.sub = sub; bus2.in_valid = 1'b1;
          g = 0;
          #1;
          while (!bus2.in_ready && g < 200) begin @(negedge clk); #1; g++; end
          if (!bus2.in_ready) begin
            n_checks++; n_fail++;
            $display("FAIL random_accept_timeout: op %0d not accepted within 200 cycles", i);
          end
          sb_q.push_back(model(a, b, cin, sub));
        end
        @(negedge clk);
        bus2.in_valid = 1'b0;
      end
      begin : consumer
        int got, cyc; logic [9:0] e;
        got = 0; cyc = 0;
        while (got < NOPS && cyc < NOPS * 20) begin
          @(negedge clk);
          cyc++;
          bus2.out_ready = ($urandom_range(0, 3) != 0);
          if (bus2.out_valid && bus2.out_ready) begin
            got++;
            n_checks++;
            if (sb_q.size() == 0) begin
              n_fail++;
              $display("FAIL random_unexpected: result r=%h with empty scoreboard", bus2.r);
            end else begin
              e = sb_q.pop_front();
              if ({bus2.ovf, bus2.r} !== e) begin
                n_fail++;
                $display("FAIL random_op%0d: got ovf=%b r=%h, expected ovf=%b r=%h",
                         got, bus2.ovf, bus2.r, e[9], e[8:0]);
              end
            end
          end
        end
        n_checks++;
        if (got != NOPS) begin
          n_fail++;
          $display("FAIL random_count: got %0d results, expected %0d", got, NOPS);
        end
        @(negedge clk);
        bus2.out_ready = 1'b0;
      end
    join
  endtask

  task automatic test_degenerate();
    logic [8:0] r; logic ovf; int lat; logic [9:0] e;
    logic [7:0] a, b; logic cin, sub;
    sb_q.push_back({1'b0, 9'h12C});
    op8(8'hC8, 8'h64, 1'b0, 1'b0, r, ovf, lat);
    e = sb_q.pop_front();
    n_checks++;
    if ({ovf, r, lat} !== {e, 32'd1}) begin
      n_fail++;
      $display("FAIL d8_c8_64: got ovf=%b r=%h lat=%0d, expected ovf=%b r=%h lat=1",
               ovf, r, lat, e[9], e[8:0]);
    end
    for (int i = 0; i < 100; i++) begin
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      sb_q.push_back(model(a, b, cin, sub));
      op8(a, b, cin, sub, r, ovf, lat);
      e = sb_q.pop_front();
      n_checks++;
      if ({ovf, r, lat} !== {e, 32'd1}) begin
        n_fail++;
        $display("FAIL d8_random%0d: a=%h b=%h cin=%b sub=%b got ovf=%b r=%h lat=%0d, expected ovf=%b r=%h lat=1",
                 i, a, b, cin, sub, ovf, r, lat, e[9], e[8:0]);
      end
    end
  endtask

  initial begin
    bus2.in_valid = 1'b0; bus2.a = '0; bus2.b = '0; bus2.cin = 1'b0; bus2.sub = 1'b0;
    bus2.out_ready = 1'b0;
    bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0; bus8.sub = 1'b0;
    bus8.out_ready = 1'b0;
    test_reset();
    test_add();
    test_carry_ovf();
    test_sub();
    test_back_to_back();
    test_random();
    test_degenerate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
